seq_alu: RTL and testbench

//   Parametrised multi-cycle ALU for the pipeline EX stage: next generation of the single-cycle ALU.

---
 rtl/seq_alu.sv | 153 +++++++++++++++
 tb/tb_seq_alu.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Multi-cycle ALU for the EX stage: single-cycle logic/arith ops plus iterative
// MUL (shift-add) and DIVU/REMU (restoring divide), with valid/ready on both sides.
module seq_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [3:0]       operation,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             div0
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLL  = 4'd6;
   localparam logic [3:0] OP_SRL  = 4'd7;
   localparam logic [3:0] OP_MUL  = 4'd8;
   localparam logic [3:0] OP_DIVU = 4'd9;
   localparam logic [3:0] OP_REMU = 4'd10;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t state, state_next;

   logic [3:0]       op_q;
   logic [WIDTH-1:0] opa, opb, acc, quo;
   logic [CW-1:0]    cnt;

   logic             accept, is_div, in2_zero, iterative;
   logic [CW-1:0]    shamt;
   logic [WIDTH-1:0] comb_res;

   assign accept    = in_valid && in_ready;
   assign shamt     = in2[CW-1:0];
   assign is_div    = (operation == OP_DIVU) || (operation == OP_REMU);
   assign in2_zero  = (in2 == '0);
   assign iterative = (operation == OP_MUL) || (is_div && !in2_zero);

   // Single-cycle results; the DIVU/REMU arms only matter on the divide-by-zero path.
   always_comb begin
      // NOTE: default first so every path assigns the variable and no latch is inferred.
      comb_res = '0;
      case (operation)
         OP_ADD:  comb_res = in1 + in2;
         OP_SUB:  comb_res = in1 - in2;
         OP_AND:  comb_res = in1 & in2;
         OP_OR:   comb_res = in1 | in2;
         OP_XOR:  comb_res = in1 ^ in2;
         OP_SLT:  comb_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
         OP_SLL:  comb_res = in1 << shamt;
         OP_SRL:  comb_res = in1 >> shamt;
         OP_DIVU: comb_res = '1;
         OP_REMU: comb_res = in1;
         default: comb_res = '0;
      endcase
   end

   // One iteration, MSB first over bit index cnt; acc is the partial product or remainder.
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH-1:0] rem_sub, mul_next, acc_nx, quo_nx, res_nx;
   logic             ge;

   assign rem_shift = {acc, opa[cnt]};
   assign ge        = rem_shift >= {1'b0, opb};
   assign rem_sub   = rem_shift[WIDTH-1:0] - opb;
   assign mul_next  = {acc[WIDTH-2:0], 1'b0} + (opb[cnt] ? opa : '0);

   always_comb begin
      acc_nx = acc;
      quo_nx = quo;
      if (op_q == OP_MUL) begin
         acc_nx = mul_next;
      end else begin
         acc_nx = ge ? rem_sub : rem_shift[WIDTH-1:0];
         quo_nx = {quo[WIDTH-2:0], ge};
      end
      res_nx = (op_q == OP_DIVU) ? quo_nx : acc_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = iterative ? BUSY : DONE;
         end
         BUSY: if (cnt == '0) state_next = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         out  <= '0;
         zero <= 1'b0;
         div0 <= 1'b0;
         op_q <= '0;
         opa  <= '0;
         opb  <= '0;
         acc  <= '0;
         quo  <= '0;
         cnt  <= '0;
      end else if (accept) begin
         op_q <= operation;
         opa  <= in1;
         opb  <= in2;
         acc  <= '0;
         quo  <= '0;
         cnt  <= CW'(WIDTH - 1);
         if (!iterative) begin
            out  <= comb_res;
            zero <= (comb_res == '0);
            div0 <= is_div && in2_zero;
         end
      end else if (state == BUSY) begin
         acc <= acc_nx;
         quo <= quo_nx;
         if (cnt == '0) begin
            out  <= res_nx;
            zero <= (res_nx == '0);
            div0 <= 1'b0;
         end else begin
            cnt <= cnt - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Randomized and directed bench for seq_alu (WIDTH=32) against an arithmetic
// reference model of each opcode, its latency and its handshake behaviour.
module tb_seq_alu;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, out_valid, out_ready, zero, div0;
   logic [W-1:0] in1, in2, out;
   logic [3:0]   operation;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .operation (operation),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .zero      (zero),
      .div0      (div0)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd6:    return a << b[4:0];
         4'd7:    return a >> b[4:0];
         4'd8:    return a * b;
         4'd9:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
         4'd10:   return (b == 0) ? a : a % b;
         default: return '0;
      endcase
   endfunction

   function automatic int model_lat(input logic [3:0] op, input logic [W-1:0] b);
      if (op == 4'd8) return W + 1;
      if ((op == 4'd9 || op == 4'd10) && b != 0) return W + 1;
      return 1;
   endfunction

   // Issue one op, scramble the inputs after accept, check latency, result, flags,
   // stability while out_ready is withheld for 'hold' cycles, and the handoff back to IDLE.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int hold);
      logic [W-1:0] exp;
      int           lat, k;
      bit           got, ready_seen;
      exp = model(op, a, b);
      lat = model_lat(op, b);
      @(negedge clk);
      check({tag, "/in_ready_idle"}, in_ready, 1);
      in_valid  = 1'b1;
      operation = op;
      in1       = a;
      in2       = b;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      operation = 4'($urandom);
      in1       = $urandom;
      in2       = $urandom;
      got        = 1'b0;
      ready_seen = 1'b0;
      for (k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (out_valid) begin
            got = 1'b1;
            break;
         end
         if (in_ready) ready_seen = 1'b1;
      end
      check({tag, "/latency"}, k, lat);
      if (!got) return;
      check({tag, "/in_ready_busy"}, ready_seen, 0);
      check({tag, "/out"}, out, exp);
      check({tag, "/zero"}, zero, exp == 0);
      check({tag, "/div0"}, div0, (op == 4'd9 || op == 4'd10) && b == 0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({tag, "/hold_out"}, out, exp);
         check({tag, "/hold_valid"}, out_valid, 1);
         check({tag, "/hold_in_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "/handoff_valid"}, out_valid, 0);
      check({tag, "/handoff_in_ready"}, in_ready, 1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]   r_op;
      logic [W-1:0] r_a, r_b;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      operation = '0;
      in1       = '0;
      in2       = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset/in_ready", in_ready, 1);
      check("reset/out_valid", out_valid, 0);
      check("reset/out", out, 0);
      check("reset/zero", zero, 0);
      check("reset/div0", div0, 0);
      rst = 1'b0;

      run_op("add_1_1", 4'd0, 32'd1, 32'd1, 0);
      run_op("sub_1_1", 4'd1, 32'd1, 32'd1, 0);
      run_op("slt_neg", 4'd5, 32'hFFFF_FFFF, 32'd1, 0);
      run_op("srl_31", 4'd7, 32'h8000_0000, 32'd31, 0);
      run_op("sll_33", 4'd6, 32'd1, 32'd33, 0);
      run_op("mul", 4'd8, 32'h0001_0000, 32'h0001_0003, 0);
      run_op("divu_100_7", 4'd9, 32'd100, 32'd7, 0);
      run_op("remu_100_7", 4'd10, 32'd100, 32'd7, 0);
      run_op("divu_by0", 4'd9, 32'd5, 32'd0, 0);
      run_op("remu_by0", 4'd10, 32'd5, 32'd0, 0);
      run_op("rsvd_op", 4'd13, 32'd9, 32'd4, 0);
      run_op("hold5", 4'd2, 32'hF0F0_1234, 32'hFF00_FF00, 5);

      // Reset in the middle of a divide discards it; the previous nonzero out is cleared.
      @(negedge clk);
      check("rst_busy/in_ready_idle", in_ready, 1);
      in_valid  = 1'b1;
      operation = 4'd9;
      in1       = 32'd1000;
      in2       = 32'd3;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("rst_busy/still_busy", {in_ready, out_valid}, 2'b00);
      rst = 1'b1;
      @(negedge clk);
      check("rst_busy/in_ready", in_ready, 1);
      check("rst_busy/out_valid", out_valid, 0);
      check("rst_busy/out", out, 0);
      rst = 1'b0;
      run_op("after_rst_add", 4'd0, 32'd20, 32'd22, 0);

      for (int i = 0; i < 50; i++) begin
         r_op = 4'($urandom_range(0, 15));
         r_a  = $urandom;
         r_b  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
         if ($urandom_range(0, 3) == 0) r_b = r_b & 32'h0000_00FF;
         run_op($sformatf("rnd%0d_op%0d", i, r_op), r_op, r_a, r_b, $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
